// File: rtl/matmul_pkg.sv
// Shared types, default latencies and the config legality check
// for the matrix-multiply sequencing controller.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam int RD_LAT_DEF   = 1;
  localparam int TREE_LAT_DEF = 7;

  // A job needs at least one row and one column, and no more than the memories hold.
  function automatic logic cfg_legal(input int unsigned rows,
                                     input int unsigned cols,
                                     input int unsigned max_dim);
    return (rows != 0) && (cols != 0) && (rows <= max_dim) && (cols <= max_dim);
  endfunction

endpackage

// File: rtl/matmul_seq_ctrl_delay.sv
// Fixed-depth shift register of {valid, data}. It has an async clear and a
// synchronous flush, and it reports whether any entry will still be in flight next cycle.
module valid_delay_line #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             pending
);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] data [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) data[k] <= '0;
    end else begin
      vld     <= flush ? '0 : {vld[DEPTH-2:0], in_valid};
      data[0] <= in_data;
      for (int k = 1; k < DEPTH; k++) data[k] <= data[k-1];
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  // Only the last stage is leaving this cycle; anything earlier still has to come out.
  assign pending   = |vld[DEPTH-2:0];

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the dot-product datapath: it streams (i, j) read pairs and then
// retires each result to output memory after the read and adder-tree latency.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int OUT_ADDR_W = 12,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int TREE_LAT   = TREE_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  pause,
  input  logic [ADDR_W:0]       cfg_rows,
  input  logic [ADDR_W:0]       cfg_cols,
  input  logic                  cfg_accum,
  output logic                  en_a,
  output logic                  en_b,
  output logic [ADDR_W-1:0]     addr_a,
  output logic [ADDR_W-1:0]     addr_b,
  output logic                  en_out,
  output logic                  we_out,
  output logic [OUT_ADDR_W-1:0] addr_out,
  output logic                  out_accum,
  output logic                  busy,
  output logic                  done,
  output logic                  err_cfg
);

  localparam int PIPE_LAT = RD_LAT + TREE_LAT;

  state_t                state, state_next;
  logic [ADDR_W-1:0]     i, j;
  logic [OUT_ADDR_W:0]   idx;
  logic [ADDR_W:0]       rows_q, cols_q;
  logic                  accum_q;
  logic                  legal, accept, start_illegal;
  logic                  issue, i_last, j_last, final_issue, flush;
  logic                  out_valid, pending;
  logic [OUT_ADDR_W-1:0] out_data;

  assign legal         = cfg_legal(32'(cfg_rows), 32'(cfg_cols), 32'(2**ADDR_W));
  assign accept        = (state == IDLE) && start && legal;
  assign start_illegal = (state == IDLE) && start && !legal;
  // The extra index bit is a guard: once it is set, no further issue can corrupt addr_out.
  assign issue         = (state == ISSUE) && !pause && !idx[OUT_ADDR_W];
  assign i_last        = ({1'b0, i} == rows_q - 1'b1);
  assign j_last        = ({1'b0, j} == cols_q - 1'b1);
  assign final_issue   = issue && i_last && j_last;
  assign flush         = abort && (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      idx     <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      accum_q <= 1'b0;
      err_cfg <= 1'b0;
    end else begin
      state   <= state_next;
      err_cfg <= start_illegal;
      if (accept) begin
        i       <= '0;
        j       <= '0;
        idx     <= '0;
        rows_q  <= cfg_rows;
        cols_q  <= cfg_cols;
        accum_q <= cfg_accum;
      end else if (issue) begin
        idx <= idx + 1'b1;
        if (j_last) begin
          j <= '0;
          i <= i + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   if (abort) state_next = IDLE;
               else if (final_issue) state_next = DRAIN;
      DRAIN:   if (abort) state_next = IDLE;
               else if (!pending) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  valid_delay_line #(
    .DEPTH (PIPE_LAT),
    .WIDTH (OUT_ADDR_W)
  ) u_write_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (issue),
    .in_data   (idx[OUT_ADDR_W-1:0]),
    .out_valid (out_valid),
    .out_data  (out_data),
    .pending   (pending)
  );

  assign en_a      = issue;
  assign en_b      = issue;
  assign addr_a    = i;
  assign addr_b    = j;
  assign en_out    = out_valid;
  assign we_out    = out_valid;
  assign addr_out  = out_valid ? out_data : '0;
  assign out_accum = out_valid & accum_q;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl: stimulus queues the expected reads and writes,
// and a negedge monitor pops them whenever the DUT presents a read or a write.
module tb_matmul_seq_ctrl;

  localparam int ADDR_W     = 6;
  localparam int OUT_ADDR_W = 12;

  typedef struct {
    int a;
    int b;
  } rd_exp_t;

  typedef struct {
    int   addr;
    logic accum;
  } wr_exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic                  abort = 1'b0;
  logic                  pause = 1'b0;
  logic [ADDR_W:0]       cfg_rows = '0;
  logic [ADDR_W:0]       cfg_cols = '0;
  logic                  cfg_accum = 1'b0;
  logic                  en_a, en_b, en_out, we_out, out_accum, busy, done, err_cfg;
  logic [ADDR_W-1:0]     addr_a, addr_b;
  logic [OUT_ADDR_W-1:0] addr_out;
  logic [31:0]           all_outs;

  matmul_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .pause     (pause),
    .cfg_rows  (cfg_rows),
    .cfg_cols  (cfg_cols),
    .cfg_accum (cfg_accum),
    .en_a      (en_a),
    .en_b      (en_b),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .en_out    (en_out),
    .we_out    (we_out),
    .addr_out  (addr_out),
    .out_accum (out_accum),
    .busy      (busy),
    .done      (done),
    .err_cfg   (err_cfg)
  );

  assign all_outs = {en_a, en_b, addr_a, addr_b, en_out, we_out, addr_out,
                     out_accum, busy, done, err_cfg};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  rd_exp_t exp_rd[$];
  wr_exp_t exp_wr[$];
  bit seen_rd, seen_wr;
  int first_rd_cycle, first_wr_cycle, last_wr_cycle, done_cycle;
  int wr_cnt, gap_cnt;
  int done_cnt = 0;
  int err_cnt = 0;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic failLine(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got an event, required none (cycle %0d)", name, cycle);
  endtask

  // Monitor: every read or write the DUT presents is matched against the scoreboard
  always @(negedge clk) begin : monitor
    rd_exp_t re;
    wr_exp_t wr;
    if (rst_n) begin
      if (en_a || en_b) begin
        if (exp_rd.size() == 0) failLine("unexpected_read");
        else begin
          re = exp_rd.pop_front();
          checkOutput("en_a", en_a, 1);
          checkOutput("en_b", en_b, 1);
          checkOutput("addr_a", addr_a, re.a);
          checkOutput("addr_b", addr_b, re.b);
          checkOutput("busy_on_read", busy, 1);
        end
        if (!seen_rd) first_rd_cycle = cycle;
        seen_rd = 1'b1;
      end
      if (we_out || en_out) begin
        if (exp_wr.size() == 0) failLine("unexpected_write");
        else begin
          wr = exp_wr.pop_front();
          checkOutput("we_out", we_out, 1);
          checkOutput("en_out", en_out, 1);
          checkOutput("addr_out", addr_out, wr.addr);
          checkOutput("out_accum", out_accum, wr.accum);
        end
        if (!seen_wr) first_wr_cycle = cycle;
        else if (cycle != last_wr_cycle + 1) gap_cnt++;
        seen_wr = 1'b1;
        last_wr_cycle = cycle;
        wr_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cycle = cycle;
      end
      if (err_cfg) err_cnt++;
    end
  end

  task automatic applyStimulus(input int rows, input int cols, input logic accum,
                               input int n_rd, input int n_wr, input logic with_abort);
    int k;
    @(posedge clk); #1;
    seen_rd = 1'b0;
    seen_wr = 1'b0;
    wr_cnt  = 0;
    gap_cnt = 0;
    cfg_rows  = (ADDR_W+1)'(rows);
    cfg_cols  = (ADDR_W+1)'(cols);
    cfg_accum = accum;
    start = 1'b1;
    abort = with_abort;
    k = 0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if (k < n_rd) exp_rd.push_back('{a: r, b: c});
        if (k < n_wr) exp_wr.push_back('{addr: r * cols + c, accum: accum});
        k++;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic waitDone(input int max_cycles);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    checkOutput("done_seen", done_cnt - base, 1);
  endtask

  initial begin
    int base_done, base_err;

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", all_outs, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_outputs", all_outs, 0);

    // 2x3 job: latency, order and the done pulse
    applyStimulus(2, 3, 1'b0, 6, 6, 1'b0);
    waitDone(100);
    checkOutput("first_write_latency", first_wr_cycle - first_rd_cycle, 8);
    checkOutput("done_after_last_write", done_cycle - last_wr_cycle, 1);
    checkOutput("job_2x3_writes", wr_cnt, 6);
    @(negedge clk);
    checkOutput("busy_after_done", busy, 0);
    checkOutput("done_width", done, 0);

    // 64x64 job: every address once, back to back
    applyStimulus(64, 64, 1'b0, 4096, 4096, 1'b0);
    waitDone(5000);
    checkOutput("full_writes", wr_cnt, 4096);
    checkOutput("full_gaps", gap_cnt, 0);
    checkOutput("full_last_addr_cycle", last_wr_cycle - first_rd_cycle, 4103);
    checkOutput("full_total_latency", done_cycle - first_rd_cycle, 4104);

    // 4x4 job paused for 5 cycles after the third issue
    applyStimulus(4, 4, 1'b0, 16, 16, 1'b0);
    repeat (3) @(posedge clk);
    #1 pause = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("pause_en_a", en_a, 0);
      checkOutput("pause_addr_a", addr_a, 0);
      checkOutput("pause_addr_b", addr_b, 3);
    end
    @(posedge clk); #1 pause = 1'b0;
    waitDone(100);
    checkOutput("pause_total_latency", done_cycle - first_rd_cycle, 29);
    checkOutput("pause_writes", wr_cnt, 16);

    // Abort on the 10th issue: only the writes already at the pipe exit appear
    base_done = done_cnt;
    applyStimulus(4, 4, 1'b0, 10, 2, 1'b0);
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_en_a", en_a, 0);
    repeat (20) @(negedge clk);
    checkOutput("abort_no_done", done_cnt - base_done, 0);
    checkOutput("abort_reads_left", exp_rd.size(), 0);
    checkOutput("abort_writes_left", exp_wr.size(), 0);

    // Start together with abort in IDLE: the start wins
    applyStimulus(2, 2, 1'b0, 4, 4, 1'b1);
    waitDone(100);
    checkOutput("restart_writes", wr_cnt, 4);

    // Illegal configs
    base_err = err_cnt;
    base_done = done_cnt;
    applyStimulus(0, 3, 1'b0, 0, 0, 1'b0);
    repeat (6) begin
      @(negedge clk);
      checkOutput("err_rows0_busy", busy, 0);
    end
    checkOutput("err_rows0_pulses", err_cnt - base_err, 1);
    base_err = err_cnt;
    applyStimulus(1, 65, 1'b0, 0, 0, 1'b0);
    repeat (6) begin
      @(negedge clk);
      checkOutput("err_cols65_busy", busy, 0);
    end
    checkOutput("err_cols65_pulses", err_cnt - base_err, 1);
    checkOutput("err_no_done", done_cnt - base_done, 0);

    // Accumulate pass with 64 columns
    applyStimulus(1, 64, 1'b1, 64, 64, 1'b0);
    waitDone(200);
    checkOutput("accum_writes", wr_cnt, 64);

    // 3x3 job: a stray start while busy, then reset mid-DRAIN
    applyStimulus(3, 3, 1'b0, 9, 9, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    cfg_rows = 7'd1;
    cfg_cols = 7'd1;
    cfg_accum = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrain_reset_outputs", all_outs, 0);
    checkOutput("midrain_writes_pending", exp_wr.size(), 6);
    checkOutput("midrain_reads_left", exp_rd.size(), 0);
    exp_wr.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("after_reset_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
